// File: rtl/strip_trigger_load_scheduler.sv
// Strip trigger load scheduler: buffers BCID/band-ID candidates and issues slot-aligned,
// gap-limited load pulses. Define STRIP_TRIG_DEDUP_EN to drop repeats of the last accepted push.
module strip_trigger_load_scheduler #(
    parameter int FIFO_DEPTH = 8,
    parameter int BCID_W     = 12,
    parameter int BAND_W     = 8,
    parameter int SLOT_DIV   = 4,
    parameter int MIN_GAP    = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          flush,
    input  logic                          cand_valid,
    input  logic [BCID_W-1:0]             cand_bcid,
    input  logic [BAND_W-1:0]             cand_band_id,
    input  logic                          gen_ready,
    input  logic                          clear_stats,
    output logic                          load,
    output logic [BCID_W-1:0]             load_bcid,
    output logic [BAND_W-1:0]             load_band_id,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [15:0]                   drop_count,
    output logic [1:0]                    fsm_state
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(SLOT_DIV);
    localparam int GAP_W = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
    localparam int KEY_W = BCID_W + BAND_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        ISSUE   = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

    state_t state, next_state;

    logic [CNT_W-1:0] slot_cnt;
    logic             slot_strobe;
    logic [GAP_W-1:0] gap;
    logic [KEY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [LVL_W-1:0] level;
    logic [KEY_W-1:0] cand_key;
    logic [KEY_W-1:0] head_key;
    logic             full, empty;
    logic             pop, push_ok, drop, dedup_hit;

    assign slot_strobe = (slot_cnt == CNT_W'(SLOT_DIV - 1));
    assign cand_key    = {cand_bcid, cand_band_id};
    assign head_key    = mem[rd_ptr];
    assign full        = (level == LVL_W'(FIFO_DEPTH));
    assign empty       = (level == '0);
    assign fifo_level  = level;

    // Qualifying cycle; flush suppresses any pop so a flushed entry can never be issued.
    assign pop     = slot_strobe & enable & gen_ready & ~empty & (gap == '0) & ~flush;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = cand_valid & ~flush & ~dedup_hit & (~full | pop);
    assign drop    = cand_valid & ~flush & ~dedup_hit & full & ~pop;

`ifdef STRIP_TRIG_DEDUP_EN
    logic             last_valid;
    logic [KEY_W-1:0] last_key;

    assign dedup_hit = last_valid & (last_key == cand_key);

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            last_valid <= 1'b0;
            last_key   <= '0;
        end else if (push_ok) begin
            last_valid <= 1'b1;
            last_key   <= cand_key;
        end
    end
`else
    assign dedup_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            slot_cnt <= '0;
        end else begin
            slot_cnt <= slot_cnt + CNT_W'(1);
        end
    end

    // The strobe that brings the gap to zero is not eligible: pop requires gap==0 beforehand.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            gap <= '0;
        end else if (pop) begin
            gap <= GAP_W'(MIN_GAP);
        end else if (slot_strobe && gap != '0) begin
            gap <= gap - GAP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= cand_key;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level <= level + LVL_W'(push_ok) - LVL_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            load_bcid    <= '0;
            load_band_id <= '0;
        end else if (pop) begin
            load_bcid    <= head_key[KEY_W-1:BAND_W];
            load_band_id <= head_key[BAND_W-1:0];
        end
    end

    // Clearing takes priority over a drop landing in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset_n || clear_stats) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = IDLE;
        end else if (pop) begin
            next_state = ISSUE;
        end else begin
            case (state)
                IDLE:    if (!empty) next_state = ARMED;
                ARMED:   if (empty) next_state = IDLE;
                ISSUE: begin
                    if (MIN_GAP > 0)  next_state = HOLDOFF;
                    else if (!empty)  next_state = ARMED;
                    else              next_state = IDLE;
                end
                HOLDOFF: if (gap == '0) next_state = empty ? IDLE : ARMED;
                default: next_state = IDLE;
            endcase
        end
    end

    // The load pulse is the ISSUE state itself, so it always lasts exactly one cycle.
    always_comb begin
        load      = (state == ISSUE);
        fsm_state = state;
    end

endmodule

// File: tb/tb_strip_trigger_load_scheduler.sv
// Directed bench for strip_trigger_load_scheduler (defaults FIFO_DEPTH=8, SLOT_DIV=4, MIN_GAP=2).
// Honours STRIP_TRIG_DEDUP_EN when computing the dedup expectations.
module tb_strip_trigger_load_scheduler;

    localparam int BCID_W = 12;
    localparam int BAND_W = 8;
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_HOLDOFF = 2'd3;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              enable = 1'b1;
    logic              flush = 1'b0;
    logic              cand_valid = 1'b0;
    logic [BCID_W-1:0] cand_bcid = '0;
    logic [BAND_W-1:0] cand_band_id = '0;
    logic              gen_ready = 1'b1;
    logic              clear_stats = 1'b0;
    logic              load;
    logic [BCID_W-1:0] load_bcid;
    logic [BAND_W-1:0] load_band_id;
    logic [3:0]        fifo_level;
    logic              overflow;
    logic [15:0]       drop_count;
    logic [1:0]        fsm_state;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    logic [BCID_W-1:0] exp_q[$];

    strip_trigger_load_scheduler dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush),
        .cand_valid(cand_valid), .cand_bcid(cand_bcid), .cand_band_id(cand_band_id),
        .gen_ready(gen_ready), .clear_stats(clear_stats), .load(load),
        .load_bcid(load_bcid), .load_band_id(load_band_id), .fifo_level(fifo_level),
        .overflow(overflow), .drop_count(drop_count), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // After this, the current cycle has slot counter 0 and cyc=0.
    task automatic do_reset();
        reset_n = 1'b0; enable = 1'b1; flush = 1'b0; cand_valid = 1'b0;
        gen_ready = 1'b1; clear_stats = 1'b0; cand_bcid = '0; cand_band_id = '0;
        step();
        step();
        reset_n = 1'b1;
        cyc = 0;
    endtask

    task automatic push(input logic [BCID_W-1:0] b, input logic [BAND_W-1:0] id);
        cand_valid = 1'b1; cand_bcid = b; cand_band_id = id;
        step();
        cand_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        nvec++; if (load !== 1'b0) begin nerr++; $display("FAIL reset_load got=%0b exp=0", load); end
        nvec++; if (load_bcid !== 12'h0) begin nerr++; $display("FAIL reset_bcid got=%h exp=0", load_bcid); end
        nvec++; if (load_band_id !== 8'h0) begin nerr++; $display("FAIL reset_band got=%h exp=0", load_band_id); end
        nvec++; if (fifo_level !== 4'd0) begin nerr++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
        nvec++; if (overflow !== 1'b0) begin nerr++; $display("FAIL reset_ovf got=%0b exp=0", overflow); end
        nvec++; if (drop_count !== 16'd0) begin nerr++; $display("FAIL reset_drops got=%0d exp=0", drop_count); end
        nvec++; if (fsm_state !== S_IDLE) begin nerr++; $display("FAIL reset_state got=%0d exp=%0d", fsm_state, S_IDLE); end
    endtask

    task automatic test_single();
        do_reset();
        step();                     // counter=1
        push(12'h123, 8'h45);       // counter=2
        nvec++; if (fifo_level !== 4'd1) begin nerr++; $display("FAIL single_level1 got=%0d exp=1", fifo_level); end
        step();                     // counter=3, strobe
        nvec++; if (load !== 1'b0) begin nerr++; $display("FAIL single_early got=%0b exp=0", load); end
        step();
        nvec++; if (load !== 1'b1) begin nerr++; $display("FAIL single_load got=%0b exp=1", load); end
        nvec++; if (load_bcid !== 12'h123) begin nerr++; $display("FAIL single_bcid got=%h exp=123", load_bcid); end
        nvec++; if (load_band_id !== 8'h45) begin nerr++; $display("FAIL single_band got=%h exp=45", load_band_id); end
        nvec++; if (fifo_level !== 4'd0) begin nerr++; $display("FAIL single_level0 got=%0d exp=0", fifo_level); end
        step();
        nvec++; if (load !== 1'b0) begin nerr++; $display("FAIL single_width got=%0b exp=0", load); end
        nvec++; if (fsm_state !== S_HOLDOFF) begin nerr++; $display("FAIL single_holdoff got=%0d exp=%0d", fsm_state, S_HOLDOFF); end
        nvec++; if (load_bcid !== 12'h123) begin nerr++; $display("FAIL single_hold got=%h exp=123", load_bcid); end
    endtask

    task automatic test_back_to_back();
        int exp_cyc[3];
        int n_loads;
        exp_cyc[0] = 4; exp_cyc[1] = 16; exp_cyc[2] = 28;
        n_loads = 0;
        do_reset();
        exp_q.delete();
        push(12'h201, 8'h11); exp_q.push_back(12'h201);
        push(12'h202, 8'h12); exp_q.push_back(12'h202);
        push(12'h203, 8'h13); exp_q.push_back(12'h203);
        for (int i = 0; i < 40; i++) begin
            if (load === 1'b1) begin
                nvec++;
                if (exp_q.size() == 0) begin
                    nerr++; $display("FAIL b2b_extra got=%h at cycle %0d exp=no load", load_bcid, cyc);
                end else begin
                    logic [BCID_W-1:0] e;
                    e = exp_q.pop_front();
                    if (load_bcid !== e) begin nerr++; $display("FAIL b2b_data got=%h exp=%h", load_bcid, e); end
                end
                if (n_loads < 3) begin
                    nvec++;
                    if (cyc != exp_cyc[n_loads]) begin
                        nerr++; $display("FAIL b2b_time got=%0d exp=%0d", cyc, exp_cyc[n_loads]);
                    end
                end
                n_loads++;
            end
            step();
        end
        nvec++; if (n_loads != 3) begin nerr++; $display("FAIL b2b_count got=%0d exp=3", n_loads); end
    endtask

    task automatic test_overflow();
        do_reset();
        gen_ready = 1'b0;
        for (int i = 0; i < 10; i++) push(12'(i + 1), 8'(i));
        nvec++; if (fifo_level !== 4'd8) begin nerr++; $display("FAIL ovf_level got=%0d exp=8", fifo_level); end
        nvec++; if (drop_count !== 16'd2) begin nerr++; $display("FAIL ovf_drops got=%0d exp=2", drop_count); end
        nvec++; if (overflow !== 1'b1) begin nerr++; $display("FAIL ovf_flag got=%0b exp=1", overflow); end
        clear_stats = 1'b1;
        step();
        clear_stats = 1'b0;
        nvec++; if (drop_count !== 16'd0) begin nerr++; $display("FAIL clr_drops got=%0d exp=0", drop_count); end
        nvec++; if (overflow !== 1'b0) begin nerr++; $display("FAIL clr_flag got=%0b exp=0", overflow); end
        nvec++; if (fifo_level !== 4'd8) begin nerr++; $display("FAIL clr_level got=%0d exp=8", fifo_level); end
        // Drop and clear together: the clear must win.
        cand_valid = 1'b1; cand_bcid = 12'h777; cand_band_id = 8'h77; clear_stats = 1'b1;
        step();
        cand_valid = 1'b0; clear_stats = 1'b0;
        nvec++; if (drop_count !== 16'd0) begin nerr++; $display("FAIL clrdrop_drops got=%0d exp=0", drop_count); end
        nvec++; if (overflow !== 1'b0) begin nerr++; $display("FAIL clrdrop_flag got=%0b exp=0", overflow); end
    endtask

    task automatic test_gen_ready_stall();
        int first;
        logic [BCID_W-1:0] b;
        logic [BAND_W-1:0] id;
        first = -1; b = '0; id = '0;
        do_reset();
        gen_ready = 1'b0;
        push(12'h0AA, 8'h0B);
        step();
        nvec++; if (fsm_state !== S_ARMED) begin nerr++; $display("FAIL stall_armed got=%0d exp=%0d", fsm_state, S_ARMED); end
        while (cyc < 20) begin
            if (cyc == 8) gen_ready = 1'b1;
            if (load === 1'b1 && first < 0) begin first = cyc; b = load_bcid; id = load_band_id; end
            step();
        end
        nvec++; if (first != 12) begin nerr++; $display("FAIL stall_time got=%0d exp=12", first); end
        nvec++; if (b !== 12'h0AA) begin nerr++; $display("FAIL stall_bcid got=%h exp=0aa", b); end
        nvec++; if (id !== 8'h0B) begin nerr++; $display("FAIL stall_band got=%h exp=0b", id); end
    endtask

    task automatic test_flush();
        int n_loads;
        n_loads = 0;
        do_reset();
        gen_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(12'(12'h300 + i), 8'(i + 1));
        nvec++; if (fifo_level !== 4'd4) begin nerr++; $display("FAIL flush_pre got=%0d exp=4", fifo_level); end
        flush = 1'b1; cand_valid = 1'b1; cand_bcid = 12'h0FF; cand_band_id = 8'h0F;
        step();
        flush = 1'b0; cand_valid = 1'b0; gen_ready = 1'b1;
        nvec++; if (fifo_level !== 4'd0) begin nerr++; $display("FAIL flush_level got=%0d exp=0", fifo_level); end
        nvec++; if (drop_count !== 16'd0) begin nerr++; $display("FAIL flush_drops got=%0d exp=0", drop_count); end
        for (int i = 0; i < 16; i++) begin
            if (load === 1'b1) n_loads++;
            step();
        end
        nvec++; if (n_loads != 0) begin nerr++; $display("FAIL flush_loads got=%0d exp=0", n_loads); end
    endtask

    task automatic test_reset_mid_issue();
        do_reset();
        gen_ready = 1'b0;
        for (int i = 0; i < 9; i++) push(12'(i + 1), 8'(i));
        gen_ready = 1'b1;
        step(); step(); step();
        nvec++; if (load !== 1'b1) begin nerr++; $display("FAIL midrst_pre got=%0b exp=1", load); end
        nvec++; if (overflow !== 1'b1) begin nerr++; $display("FAIL midrst_ovf got=%0b exp=1", overflow); end
        reset_n = 1'b0;
        step();
        nvec++; if (load !== 1'b0) begin nerr++; $display("FAIL midrst_load got=%0b exp=0", load); end
        nvec++; if (load_bcid !== 12'h0) begin nerr++; $display("FAIL midrst_bcid got=%h exp=0", load_bcid); end
        nvec++; if (load_band_id !== 8'h0) begin nerr++; $display("FAIL midrst_band got=%h exp=0", load_band_id); end
        nvec++; if (fifo_level !== 4'd0) begin nerr++; $display("FAIL midrst_level got=%0d exp=0", fifo_level); end
        nvec++; if (overflow !== 1'b0) begin nerr++; $display("FAIL midrst_flag got=%0b exp=0", overflow); end
        nvec++; if (drop_count !== 16'd0) begin nerr++; $display("FAIL midrst_drops got=%0d exp=0", drop_count); end
        nvec++; if (fsm_state !== S_IDLE) begin nerr++; $display("FAIL midrst_state got=%0d exp=0", fsm_state); end
        reset_n = 1'b1;
    endtask

    task automatic test_dedup();
        int n_loads;
        logic [3:0] exp_level;
        int exp_loads;
`ifdef STRIP_TRIG_DEDUP_EN
        exp_level = 4'd2; exp_loads = 2;
`else
        exp_level = 4'd3; exp_loads = 3;
`endif
        n_loads = 0;
        do_reset();
        push(12'h010, 8'h02);
        push(12'h010, 8'h02);
        push(12'h011, 8'h02);
        nvec++; if (fifo_level !== exp_level) begin nerr++; $display("FAIL dedup_level got=%0d exp=%0d", fifo_level, exp_level); end
        for (int i = 0; i < 40; i++) begin
            if (load === 1'b1) n_loads++;
            step();
        end
        nvec++; if (n_loads != exp_loads) begin nerr++; $display("FAIL dedup_loads got=%0d exp=%0d", n_loads, exp_loads); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_gen_ready_stall();
        test_flush();
        test_reset_mid_issue();
        test_dedup();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/strip_trigger_load_scheduler.md
Name: strip_trigger_load_scheduler

Overview:
- Sequences the strip trigger serializer load path.
- Buffers trigger candidates (BCID + band ID) from the logic-pad/band-ID stage in a small FIFO.
- Issues single-cycle load pulses to the strip trigger generator, only on the 1-in-SLOT_DIV slot strobe of clk, only when the generator is ready and the minimum inter-trigger gap has elapsed.
- Replaces the bare free-running 1-in-4 latch. Adds overflow accounting and a flush control.

Parameters:
- FIFO_DEPTH, 8: candidate FIFO entries; power of 2, minimum 2.
- BCID_W, 12: BCID width.
- BAND_W, 8: band ID width.
- SLOT_DIV, 4: clk cycles per load slot; power of 2, minimum 2.
- MIN_GAP, 2: slot strobes that must pass after an issue before the next issue; 0 = back-to-back slots allowed.

Ports:
- clk  in  1  fabric clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- enable  in  1  1 = issuing allowed; 0 = FIFO still fills, nothing popped.
- flush  in  1  1-cycle pulse; empties FIFO.
- cand_valid  in  1  candidate present this cycle.
- cand_bcid  in  BCID_W  candidate BCID.
- cand_band_id  in  BAND_W  candidate band ID.
- gen_ready  in  1  strip trigger generator can accept a load.
- load  out  1  1-cycle load pulse to generator.
- load_bcid  out  BCID_W  BCID accompanying load; held until next load.
- load_band_id  out  BAND_W  band ID accompanying load; held until next load.
- fifo_level  out  log2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky; set on any dropped candidate.
- drop_count  out  16  saturating count of dropped candidates.
- clear_stats  in  1  1-cycle pulse; clears overflow and drop_count.

Behaviour:
- Reset (reset_n=0 at a clk edge) forces all of the following, including mid-issue:
  - load=0, load_bcid=0, load_band_id=0.
  - fifo_level=0, overflow=0, drop_count=0.
  - slot counter=0, gap counter=0, FSM=IDLE.
- Slot counter: free-running modulo SLOT_DIV. slot_strobe is high in the cycle where counter==SLOT_DIV-1.
- Push:
  - cand_valid=1 and FIFO not full → candidate written; visible to the pop logic next cycle.
  - Full with a pop in the same cycle → push accepted; level unchanged.
  - Full with no pop → candidate dropped: overflow<=1, drop_count+1, saturating at 0xFFFF.
- Qualifying cycle = slot_strobe & enable & gen_ready & FIFO non-empty & gap counter==0 & !flush.
  - Pops the head entry.
  - Registers head into load_bcid/load_band_id.
  - Drives load=1 in the following cycle, for exactly one cycle.
- Latency: candidate pushed at cycle t into an empty FIFO, with conditions otherwise met → load at the first strobe cycle ≥t+1, plus 1 cycle.
- Gap counter:
  - Loaded with MIN_GAP on a qualifying cycle.
  - Decremented on each later slot_strobe while non-zero.
  - The strobe that decrements it to 0 is not itself eligible; eligibility starts at the next strobe.
  - Consequence: consecutive loads are separated by at least (MIN_GAP+1)*SLOT_DIV cycles.
- FSM:
  - IDLE (FIFO empty) → ARMED on non-empty.
  - ARMED → ISSUE on qualifying cycle.
  - ISSUE (load=1) → HOLDOFF if MIN_GAP>0; otherwise → ARMED if non-empty, else IDLE.
  - HOLDOFF → ARMED or IDLE when the gap counter reaches 0.
  - flush → IDLE from any state. Gap counter is not cleared by flush.
- Flush vs push in the same cycle: flush wins; the incoming candidate is discarded and not counted as a drop.
- gen_ready low at a strobe: the entry stays at the head; retried at the next strobe. No timeout.
- enable deasserted during ISSUE: the pending load pulse still completes.
- clear_stats coinciding with a drop: the clear wins (count=0, overflow=0).
- fifo_level reflects the registered occupancy after each edge.

Optional Feature:
- Macro STRIP_TRIG_DEDUP_EN.
- Defined:
  - A candidate whose {bcid, band_id} equals the last accepted push is silently discarded. It is neither a push nor a drop.
  - The last-push register is cleared by reset and by flush.
- Undefined: every valid candidate is pushed or dropped as above.

Test Plan:
- Single candidate bcid=0x123, band=0x45 pushed at counter=1, enable=1, gen_ready=1 → load=1 exactly one cycle after counter==3; load_bcid=0x123, load_band_id=0x45; fifo_level back to 0.
- Three candidates pushed back-to-back, MIN_GAP=2, SLOT_DIV=4 → three load pulses spaced exactly 12 cycles apart, in push order.
- Ten pushes with gen_ready=0, FIFO_DEPTH=8 → fifo_level=8, drop_count=2, overflow=1. clear_stats → both 0; fifo_level still 8.
- gen_ready=0 over two strobes, then 1 → no load until the first strobe with gen_ready=1; then load with the correct head data.
- Four entries queued, flush pulsed together with cand_valid → fifo_level=0 next cycle, drop_count unchanged, no load. Apply reset_n=0 during ISSUE → load=0 and all outputs 0 after the edge.
- With STRIP_TRIG_DEDUP_EN: push {0x010,0x02} twice, then {0x011,0x02} → fifo_level=2 and two loads. Without the macro → fifo_level=3 and three loads.
